cla_divider4: RTL and testbench

Sequential 4-bit unsigned restoring divider; the arithmetic inverse of the team's 4-bit carry-lookahead adder. It computes quotient and remainder one bit per clock by repeated trial subtraction through a 5-bit carry-lookahead subtractor. It sits beside the adder in the datapath and uses a start/busy/done handshake for control.

---
 rtl/cla_div_pkg.sv | 14 +
 rtl/cla_sub5.sv | 67 ++++++
 rtl/cla_divider4.sv | 116 +++++++++++
 tb/tb_cla_divider4.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_div_pkg.sv
// Shared types and constants for the 4-bit restoring divider and its
// carry-lookahead subtractor.
package cla_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int         DIV_W     = 4;
  localparam logic [1:0] ITER_LAST = 2'd3;

endpackage

// File: rtl/cla_sub5.sv
// Combinational 5-bit carry-lookahead subtractor (a - b as a + ~b + 1).
// Every gate is built from a two-input NAND.
module cla_sub5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] diff,
  output logic       borrow
);

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  function automatic logic and2(input logic x, input logic y);
    logic n;
    n = nand2(x, y);
    return nand2(n, n);
  endfunction

  function automatic logic or2(input logic x, input logic y);
    return nand2(nand2(x, x), nand2(y, y));
  endfunction

  function automatic logic xor2(input logic x, input logic y);
    logic n;
    n = nand2(x, y);
    return nand2(nand2(x, n), nand2(y, n));
  endfunction

  logic [4:0] b_n;
  logic [4:0] p;
  logic [4:0] g;
  logic [5:0] c;
  logic       acc;
  logic       pp;

  always_comb begin
    b_n = '0;
    p   = '0;
    g   = '0;
    c   = '0;
    acc = 1'b0;
    pp  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_n[i] = nand2(b[i], b[i]);
      p[i]   = xor2(a[i], b_n[i]);
      g[i]   = and2(a[i], b_n[i]);
    end
    // Carry-in of 1 completes the two's-complement negation of b.
    c[0] = 1'b1;
    // Flat lookahead: each carry sums every generate term propagated up to it.
    for (int i = 0; i < 5; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = or2(acc, and2(pp, g[j]));
        pp  = and2(pp, p[j]);
      end
      c[i+1] = or2(acc, and2(pp, c[0]));
    end
    for (int i = 0; i < 5; i++) begin
      diff[i] = xor2(p[i], c[i]);
    end
    borrow = nand2(c[5], c[5]);
  end

endmodule

// File: rtl/cla_divider4.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock,
// trial subtraction through a 5-bit carry-lookahead subtractor.
module cla_divider4
  import cla_div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is taken on any rising edge where busy=0 (IDLE or DONE);
  // busy covers the iteration cycles, done pulses once as results update, and
  // the results stay put until the next done. busy and done never overlap.

  div_state_t       state;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_r;
  logic [1:0]       cnt;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  assign trial_a   = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
  assign trial_b   = {1'b0, dsr_r};
  assign state_dbg = state;

  cla_sub5 u_sub (
    .a      (trial_a),
    .b      (trial_b),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // Restore on borrow: keep the shifted remainder and shift in a 0.
  always_comb begin
    rem_next = trial_a;
    quo_next = {quo_r[WIDTH-2:0], 1'b0};
    if (!trial_borrow) begin
      rem_next    = trial_diff;
      quo_next[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem_r       <= '0;
      quo_r       <= '0;
      dsr_r       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              rem_r <= '0;
              quo_r <= dividend;
              dsr_r <= divisor;
              cnt   <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          cnt   <= cnt + 2'd1;
          if (cnt == ITER_LAST) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= quo_next;
            remainder   <= rem_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_divider4.sv
// Self-checking bench for cla_divider4: directed scenarios, random pairs and
// an exhaustive back-to-back sweep against an arithmetic reference model.
module tb_cla_divider4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;

  cla_divider4 #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) overlap_cnt++;
  end

  // Reference model result packed as {div_by_zero, quotient, remainder}.
  function automatic logic [8:0] model(input int dd, input int dv);
    if (dv == 0) return {1'b1, 4'hF, dd[3:0]};
    return {1'b0, 4'(dd / dv), 4'(dd % dv)};
  endfunction

  // Called at a falling edge; issues one request and waits for its done.
  task automatic do_div(input logic [3:0] dd, input logic [3:0] dv,
                        output logic [8:0] got, output int lat,
                        output int bcyc, output bit timeout);
    bit fin;
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
    lat = 0; bcyc = 0; timeout = 1'b1; fin = 1'b0; got = '0;
    while (!fin && lat < 20) begin
      if (done) begin
        got = {div_by_zero, quotient, remainder};
        timeout = 1'b0;
        fin = 1'b1;
      end else begin
        if (busy) bcyc++;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [8:0] got;
    int lat, bcyc;
    bit to;
    do_div(4'd13, 4'd3, got, lat, bcyc, to);
    checks++;
    if (to) begin errors++; $display("FAIL div_13_3_timeout: no done within 20 cycles"); end
    checks++;
    if (got !== model(13, 3)) begin
      errors++; $display("FAIL div_13_3: got %h expected %h", got, model(13, 3));
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL div_13_3_latency: got %0d expected 4", lat); end
    checks++;
    if (bcyc !== 4) begin errors++; $display("FAIL div_13_3_busy: got %0d cycles expected 4", bcyc); end
    do_div(4'd15, 4'd1, got, lat, bcyc, to);
    checks++;
    if (got !== 9'h0F0 || to) begin
      errors++; $display("FAIL div_15_1: got %h expected 0f0", got);
    end
    do_div(4'd5, 4'd7, got, lat, bcyc, to);
    checks++;
    if (got !== 9'h005 || to) begin
      errors++; $display("FAIL div_5_7: got %h expected 005", got);
    end
  endtask

  task automatic test_zero_divisor();
    logic [8:0] got;
    int lat, bcyc;
    bit to;
    do_div(4'd9, 4'd0, got, lat, bcyc, to);
    checks++;
    if (got !== 9'h1F9 || to) begin
      errors++; $display("FAIL div_9_0: got %h expected 1f9", got);
    end
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL div_9_0_latency: got %0d expected 0", lat); end
    checks++;
    if (bcyc !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL div_9_0_busy: got %0d busy cycles, busy=%b expected 0", bcyc, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL div_9_0_pulse: done got %b expected 0", done); end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    logic [8:0] got = '0;
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) got = {div_by_zero, quotient, remainder};
      end
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    checks++;
    if (got !== 9'h032) begin errors++; $display("FAIL ignore_result: got %h expected 032", got); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    logic [8:0] got;
    int lat, bcyc;
    bit to;
    start = 1'b1; dividend = 4'd11; divisor = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d activity cycles expected 0", ndone); end
    do_div(4'd11, 4'd3, got, lat, bcyc, to);
    checks++;
    if (got !== 9'h032 || to) begin
      errors++; $display("FAIL reset_mid_rerun: got %h expected 032", got);
    end
  endtask

  task automatic test_random();
    logic [8:0] got;
    logic [3:0] dd, dv;
    int lat, bcyc;
    bit to;
    for (int k = 0; k < 24; k++) begin
      dd = 4'($urandom_range(0, 15));
      dv = 4'($urandom_range(0, 15));
      do_div(dd, dv, got, lat, bcyc, to);
      checks++;
      if (to || got !== model(dd, dv) || lat !== ((dv == 0) ? 0 : 4)) begin
        errors++;
        $display("FAIL random_%0d_%0d: got %h lat %0d expected %h lat %0d",
                 dd, dv, got, lat, model(dd, dv), (dv == 0) ? 0 : 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [8:0] e, got;
    int idx = 0, ndone = 0, cyc = 0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    while ((idx < 256 || exp_q.size() > 0) && cyc < 3000) begin
      if (done) begin
        ndone++;
        got = {div_by_zero, quotient, remainder};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_done: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++; $display("FAIL b2b_result: got %h expected %h", got, e);
          end
        end
      end
      if (!busy && idx < 256) begin
        dividend = 4'(idx >> 4);
        divisor  = 4'(idx);
        exp_q.push_back(model(idx >> 4, idx & 15));
        idx++;
      end else if (idx >= 256) begin
        start = 1'b0;
      end else begin
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (ndone !== 256 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d dones, %0d pending expected 256, 0", ndone, exp_q.size());
    end
  endtask

  task automatic test_handshake_excl();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++; $display("FAIL busy_done_overlap: got %0d cycles expected 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_divisor();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_handshake_excl();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
